// File: rtl/lc3_io_pkg.sv
// Shared definitions for the LC-3 memory-mapped character I/O blocks
// (display transmitter, keyboard receiver, address decoder).
package lc3_io_pkg;

   localparam logic [1:0] IDLE  = 2'd0;
   localparam logic [1:0] START = 2'd1;
   localparam logic [1:0] DATA  = 2'd2;
   localparam logic [1:0] STOP  = 2'd3;

   typedef enum logic [1:0] {
      S_IDLE  = IDLE,
      S_START = START,
      S_DATA  = DATA,
      S_STOP  = STOP
   } uart_state_e;

   localparam int DSR_READY_BIT  = 15;
   localparam int UART_DATA_BITS = 8;

   localparam logic [15:0] DSR_ADDR = 16'hFE04;
   localparam logic [15:0] DDR_ADDR = 16'hFE06;

endpackage

// File: rtl/uart_baud_tick.sv
// Bit-period timer: tick marks the last clock cycle of every UART bit.
// Holding clear keeps the count at zero so the next period starts aligned.
module uart_baud_tick #(
   parameter int CLKS_PER_BIT = 868
) (
   input  logic clock,
   input  logic reset,
   input  logic clear,
   output logic tick
);

   localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [CW-1:0] LAST = CW'(CLKS_PER_BIT - 1);

   logic [CW-1:0] cnt;

   // NOTE: sequential state uses non-blocking (<=) so every flop samples
   // pre-edge values; blocking here would create order-dependent races.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         cnt <= '0;
      end else if (clear || cnt == LAST) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + CW'(1);
      end
   end

   assign tick = (cnt == LAST);

endmodule

// File: rtl/lc3_display_tx.sv
// LC-3 display data register drained as an 8N1 UART frame, with the display
// status register (ready in bit 15) exposed for CPU polling.
module lc3_display_tx
   import lc3_io_pkg::*;
#(
   parameter int DATA_WIDTH   = 16,
   parameter int CLKS_PER_BIT = 868
) (
   input  logic                  clock,
   input  logic                  reset,
   input  logic                  load,
   input  logic [DATA_WIDTH-1:0] in_data,
   output logic [DATA_WIDTH-1:0] dsr_out,
   output logic                  busy,
   output logic                  tx
);

   localparam int BW = $clog2(UART_DATA_BITS);
   localparam logic [BW-1:0] LAST_BIT = BW'(UART_DATA_BITS - 1);

   uart_state_e               state_q, state_d;
   logic [UART_DATA_BITS-1:0] shift_q, shift_d;
   logic [BW-1:0]             bit_cnt_q, bit_cnt_d;
   logic                      tx_q, tx_d;
   logic                      busy_q, busy_d;
   logic                      tick;

   // The upper byte of the DDR word is architecturally ignored.
   logic unused_upper;
   assign unused_upper = ^in_data[DATA_WIDTH-1:UART_DATA_BITS];

   uart_baud_tick #(
      .CLKS_PER_BIT (CLKS_PER_BIT)
   ) u_baud (
      .clock (clock),
      .reset (reset),
      .clear (state_q == S_IDLE),
      .tick  (tick)
   );

   // NOTE: every signal assigned in always_comb gets a default first;
   // any path that leaves one unassigned would infer a latch.
   always_comb begin
      state_d   = state_q;
      shift_d   = shift_q;
      bit_cnt_d = bit_cnt_q;
      unique case (state_q)
         S_IDLE: begin
            if (load) begin
               shift_d   = in_data[UART_DATA_BITS-1:0];
               bit_cnt_d = '0;
               state_d   = S_START;
            end
         end
         S_START: begin
            if (tick) state_d = S_DATA;
         end
         S_DATA: begin
            if (tick) begin
               shift_d   = {1'b0, shift_q[UART_DATA_BITS-1:1]};
               bit_cnt_d = bit_cnt_q + BW'(1);
               if (bit_cnt_q == LAST_BIT) state_d = S_STOP;
            end
         end
         S_STOP: begin
            if (tick) state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase

      // Outputs are decoded from the next state so they leave a flop.
      unique case (state_d)
         S_START: tx_d = 1'b0;
         S_DATA:  tx_d = shift_d[0];
         default: tx_d = 1'b1;
      endcase
      busy_d = (state_d != S_IDLE);
   end

   // NOTE: the shift register is an ordinary flop bank, so it is reset along
   // with the control state; only true RAM arrays are left without reset.
   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q   <= S_IDLE;
         shift_q   <= '0;
         bit_cnt_q <= '0;
         tx_q      <= 1'b1;
         busy_q    <= 1'b0;
      end else begin
         state_q   <= state_d;
         shift_q   <= shift_d;
         bit_cnt_q <= bit_cnt_d;
         tx_q      <= tx_d;
         busy_q    <= busy_d;
      end
   end

   always_comb begin
      dsr_out                = '0;
      dsr_out[DSR_READY_BIT] = ~busy_q;
   end

   assign busy = busy_q;
   assign tx   = tx_q;

endmodule

// File: tb/tb_lc3_display_tx.sv
// Scoreboard bench for lc3_display_tx: stimulus queues expected characters,
// a monitor reassembles each serial frame from tx and scores it.
module tb_lc3_display_tx;

   localparam int DW    = 16;
   localparam int CPB   = 4;
   localparam int FRAME = 10 * CPB;

   typedef struct {
      logic [7:0] data;
      int         gap;
   } exp_t;

   logic          clock   = 1'b0;
   logic          reset   = 1'b1;
   logic          load    = 1'b0;
   logic [DW-1:0] in_data = '0;
   logic [DW-1:0] dsr_out;
   logic          busy;
   logic          tx;

   exp_t sb_q[$];
   int   checks     = 0;
   int   errors     = 0;
   int   exp_frames = 0;
   int   got_frames = 0;

   int             mon_len  = 0;
   int             mon_gap  = -1;
   int             mon_fgap = -1;
   logic           mon_dsr_bad = 1'b0;
   logic [FRAME-1:0] mon_samp = '0;

   always #5 clock = ~clock;

   lc3_display_tx #(
      .DATA_WIDTH   (DW),
      .CLKS_PER_BIT (CPB)
   ) dut (
      .clock   (clock),
      .reset   (reset),
      .load    (load),
      .in_data (in_data),
      .dsr_out (dsr_out),
      .busy    (busy),
      .tx      (tx)
   );

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      checks++;
      if (act !== req) begin
         errors++;
         $display("FAIL %s: got %0h, want %0h", name, act, req);
      end
   endtask

   task automatic score(input int len, input logic [FRAME-1:0] s, input int fgap,
                        input logic dsr_bad);
      exp_t       e;
      logic [7:0] data;
      logic       stable;
      got_frames++;
      for (int b = 0; b < 8; b++) data[b] = s[(b + 1) * CPB];
      if (sb_q.size() == 0) begin
         checks++;
         errors++;
         $display("FAIL unexpected_frame: got frame %0h, want no frame", data);
         return;
      end
      e = sb_q.pop_front();
      stable = 1'b1;
      for (int b = 0; b < 10; b++)
         for (int k = 1; k < CPB; k++)
            if (s[b * CPB + k] !== s[b * CPB]) stable = 1'b0;
      check("frame_len", len, FRAME);
      check("bit_stable", stable, 1);
      check("start_bit", s[0], 0);
      check("data", data, e.data);
      check("stop_bit", s[9 * CPB], 1);
      check("dsr_while_busy", dsr_bad, 0);
      if (e.gap >= 0) check("idle_gap", fgap, e.gap);
   endtask

   // NOTE: the monitor samples on the falling edge, half a period away from
   // the edge where the DUT updates, so it never races the flops.
   initial begin : monitor
      forever begin
         @(negedge clock);
         if (!reset) begin
            mon_len = 0;
            mon_gap = -1;
         end else if (busy) begin
            if (mon_len == 0) begin
               mon_fgap    = mon_gap;
               mon_dsr_bad = 1'b0;
            end
            if (dsr_out !== '0) mon_dsr_bad = 1'b1;
            if (mon_len < FRAME) mon_samp[mon_len] = tx;
            mon_len++;
         end else if (mon_len > 0) begin
            check("dsr_ready_after", dsr_out, 16'h8000);
            score(mon_len, mon_samp, mon_fgap, mon_dsr_bad);
            mon_len = 0;
            mon_gap = 1;
         end else if (mon_gap >= 0) begin
            mon_gap++;
         end
      end
   end

   task automatic pulse_load(input logic [DW-1:0] d);
      in_data = d;
      load    = 1'b1;
      @(negedge clock);
      load    = 1'b0;
   endtask

   task automatic send(input logic [DW-1:0] d, input int gap);
      exp_t e;
      e.data = d[7:0];
      e.gap  = gap;
      sb_q.push_back(e);
      exp_frames++;
      pulse_load(d);
   endtask

   task automatic wait_idle(input int budget);
      int n = 0;
      while ((busy || sb_q.size() != 0) && n < budget) begin
         @(negedge clock);
         n++;
      end
      if (busy || sb_q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL idle_timeout: still busy after %0d cycles, want idle", budget);
      end
      @(negedge clock);
   endtask

   initial begin : stimulus
      int n;
      #1 reset = 1'b0;
      #1;
      check("rst_tx", tx, 1);
      check("rst_dsr", dsr_out, 16'h8000);
      check("rst_busy", busy, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);

      // 'A' with a nonzero upper byte, then the 0x55 pattern.
      send(16'h1241, -1);
      wait_idle(200);
      send(16'hFF55, -1);
      wait_idle(200);

      // Writes mid-frame and in the final stop cycle are dropped.
      send(16'h0041, -1);
      repeat (18) @(negedge clock);
      pulse_load(16'h005A);
      repeat (20) @(negedge clock);
      in_data = 16'h0066;
      load    = 1'b1;
      @(negedge clock);
      load    = 1'b0;
      check("load_in_stop_ignored", busy, 0);
      wait_idle(200);
      repeat (20) @(negedge clock);

      // Back-to-back: reload on the first ready cycle.
      send(16'h0041, -1);
      n = 0;
      while (!dsr_out[15] && n < 100) begin
         @(negedge clock);
         n++;
      end
      if (!dsr_out[15]) begin
         checks++;
         errors++;
         $display("FAIL b2b_ready_timeout: ready still %0b, want 1", dsr_out[15]);
      end
      send(16'h005A, 1);
      wait_idle(200);

      // Load held high for several cycles starts exactly one frame.
      exp_frames++;
      sb_q.push_back('{data: 8'h33, gap: -1});
      in_data = 16'h0133;
      load    = 1'b1;
      repeat (6) @(negedge clock);
      load    = 1'b0;
      wait_idle(200);

      // Reset mid-frame, then a clean frame.
      pulse_load(16'h0041);
      repeat (14) @(negedge clock);
      check("pre_abort_tx", tx, 0);
      #1 reset = 1'b0;
      #1;
      check("abort_tx", tx, 1);
      check("abort_dsr", dsr_out, 16'h8000);
      check("abort_busy", busy, 0);
      @(negedge clock);
      @(negedge clock);
      reset = 1'b1;
      @(negedge clock);
      send(16'h0030, -1);
      wait_idle(200);

      repeat (60) @(negedge clock);
      check("frame_count", got_frames, exp_frames);
      check("queue_empty", sb_q.size(), 0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   initial begin : watchdog
      #200000;
      $display("FAIL watchdog: simulation time limit reached, want completion");
      $fatal(1, "watchdog expired");
   end

endmodule
